// File: rtl/icetap_capture_ctrl.sv
// Capture sequencer for the icetap logic analyzer: arms on start, waits for an
// acceptable trigger, fills the post-trigger window and reports the RAM layout.
module icetap_capture_ctrl #(
  parameter int NR_SIGNALS    = 4,
  parameter int RECORD_DEPTH  = 4,
  parameter int RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
  input  logic                     src_clk,
  input  logic                     src_reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               trigger_pos,
  input  logic                     store_hit,
  input  logic                     trigger_hit,
  input  logic [NR_SIGNALS-1:0]    signals_in,
  output logic                     ram_wr_ena,
  output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
  output logic [NR_SIGNALS-1:0]    ram_wr_data,
  output logic [1:0]               state,
  output logic [RAM_ADDR_BITS-1:0] start_addr,
  output logic [RAM_ADDR_BITS-1:0] trigger_addr,
  output logic [RAM_ADDR_BITS-1:0] stop_addr,
  output logic                     done
);

  localparam int AW = RAM_ADDR_BITS;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(RECORD_DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_C  = AW'(RECORD_DEPTH - 1);
  localparam logic [AW-1:0] HALF_C  = AW'(RECORD_DEPTH / 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRE_TRIGGER  = 2'd1,
    POST_TRIGGER = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t        cur_state, nxt_state;
  logic [AW-1:0] wr_ptr, wr_ptr_n, ptr_inc;
  logic [AW:0]   fill, fill_n, fill_inc;
  logic [AW:0]   post_left, post_left_n;
  logic [AW-1:0] pre_needed, pre_needed_n, post_needed, post_needed_n;
  logic [AW-1:0] pos_pre;
  logic [AW-1:0] start_addr_n, trigger_addr_n, stop_addr_n;
  logic          wr_ena_n, done_n;

  assign state    = cur_state;
  assign ptr_inc  = wr_ptr + AW'(1);
  assign fill_inc = (fill == DEPTH_C) ? fill : fill + ONE_C;

  always_comb begin
    case (trigger_pos)
      2'd0:    pos_pre = '0;
      2'd2:    pos_pre = LAST_C;
      default: pos_pre = HALF_C;
    endcase
  end

  always_comb begin
    nxt_state      = cur_state;
    wr_ptr_n       = wr_ptr;
    fill_n         = fill;
    post_left_n    = post_left;
    pre_needed_n   = pre_needed;
    post_needed_n  = post_needed;
    start_addr_n   = start_addr;
    trigger_addr_n = trigger_addr;
    stop_addr_n    = stop_addr;
    wr_ena_n       = 1'b0;
    done_n         = 1'b0;

    if (abort) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE, DONE: begin
          if (start) begin
            pre_needed_n  = pos_pre;
            post_needed_n = LAST_C - pos_pre;
            wr_ptr_n      = '0;
            fill_n        = '0;
            nxt_state     = PRE_TRIGGER;
          end
        end
        PRE_TRIGGER: begin
          if (trigger_hit && (fill >= {1'b0, pre_needed})) begin
            wr_ena_n       = 1'b1;
            wr_ptr_n       = ptr_inc;
            fill_n         = fill_inc;
            trigger_addr_n = wr_ptr;
            if (post_needed == '0) begin
              stop_addr_n  = wr_ptr;
              start_addr_n = (fill_inc == DEPTH_C) ? ptr_inc : '0;
              done_n       = 1'b1;
              nxt_state    = DONE;
            end else begin
              post_left_n = {1'b0, post_needed};
              nxt_state   = POST_TRIGGER;
            end
          end else if (store_hit) begin
            wr_ena_n = 1'b1;
            wr_ptr_n = ptr_inc;
            fill_n   = fill_inc;
          end
        end
        POST_TRIGGER: begin
          if (store_hit) begin
            wr_ena_n    = 1'b1;
            wr_ptr_n    = ptr_inc;
            fill_n      = fill_inc;
            post_left_n = post_left - ONE_C;
            if (post_left == ONE_C) begin
              stop_addr_n  = wr_ptr;
              start_addr_n = (fill_inc == DEPTH_C) ? ptr_inc : '0;
              done_n       = 1'b1;
              nxt_state    = DONE;
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk or posedge src_reset) begin
    if (src_reset) begin
      cur_state    <= IDLE;
      wr_ptr       <= '0;
      fill         <= '0;
      post_left    <= '0;
      pre_needed   <= '0;
      post_needed  <= '0;
      start_addr   <= '0;
      trigger_addr <= '0;
      stop_addr    <= '0;
      done         <= 1'b0;
      ram_wr_ena   <= 1'b0;
      ram_wr_addr  <= '0;
      ram_wr_data  <= '0;
    end else begin
      cur_state    <= nxt_state;
      wr_ptr       <= wr_ptr_n;
      fill         <= fill_n;
      post_left    <= post_left_n;
      pre_needed   <= pre_needed_n;
      post_needed  <= post_needed_n;
      start_addr   <= start_addr_n;
      trigger_addr <= trigger_addr_n;
      stop_addr    <= stop_addr_n;
      done         <= done_n;
      ram_wr_ena   <= wr_ena_n;
      if (wr_ena_n) begin
        ram_wr_addr <= wr_ptr;
        ram_wr_data <= signals_in;
      end
    end
  end

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Scoreboard bench for icetap_capture_ctrl: a sample-count reference model
// queues expected per-cycle outputs and RAM writes; a monitor pops and compares.
module tb_icetap_capture_ctrl;

  localparam int D = 8;

  logic       src_clk = 1'b0;
  logic       src_reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic [1:0] trigger_pos = 2'd0;
  logic       store_hit = 1'b0, trigger_hit = 1'b0;
  logic [3:0] signals_in = 4'd0;
  logic       ram_wr_ena;
  logic [2:0] ram_wr_addr;
  logic [3:0] ram_wr_data;
  logic [1:0] state;
  logic [2:0] start_addr, trigger_addr, stop_addr;
  logic       done;

  icetap_capture_ctrl #(.NR_SIGNALS(4), .RECORD_DEPTH(D)) dut (
    .src_clk(src_clk), .src_reset(src_reset), .start(start), .abort(abort),
    .trigger_pos(trigger_pos), .store_hit(store_hit), .trigger_hit(trigger_hit),
    .signals_in(signals_in), .ram_wr_ena(ram_wr_ena), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .state(state), .start_addr(start_addr),
    .trigger_addr(trigger_addr), .stop_addr(stop_addr), .done(done)
  );

  always #5 src_clk = ~src_clk;

  typedef struct { int st; int ena; int dn; int trig; int stop; int strt; } cyc_t;
  typedef struct { int addr; int data; } wr_t;
  cyc_t cq[$];
  wr_t  wq[$];

  int n_chk = 0, n_fail = 0;
  bit mon_on = 0;

  // reference model: capture described by number of samples written so far
  int phase = 0, nw = 0, pre_n = 0, post_n = 0, post_cnt = 0;
  int m_trig = 0, m_stop = 0, m_start = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_capture(inout bit dn);
    m_stop  = (nw - 1) % D;
    m_start = (nw >= D) ? nw % D : 0;
    phase   = 3;
    dn      = 1;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit [1:0] pos,
                            input bit sh, input bit th, input int sig);
    bit wr = 0, dn = 0;
    int addr = nw % D;
    int filled = (nw < D) ? nw : D;
    cyc_t e;
    if (ab) phase = 0;
    else if ((phase == 0 || phase == 3) && st) begin
      pre_n  = (pos == 0) ? 0 : (pos == 2) ? D - 1 : D / 2;
      post_n = D - 1 - pre_n;
      nw     = 0;
      phase  = 1;
    end else if (phase == 1) begin
      if (th && filled >= pre_n) begin
        wr = 1; m_trig = addr; nw++;
        if (post_n == 0) finish_capture(dn);
        else begin post_cnt = 0; phase = 2; end
      end else if (sh) begin
        wr = 1; nw++;
      end
    end else if (phase == 2 && sh) begin
      wr = 1; nw++; post_cnt++;
      if (post_cnt == post_n) finish_capture(dn);
    end
    if (wr) wq.push_back('{addr: addr, data: sig});
    e = '{st: phase, ena: int'(wr), dn: int'(dn), trig: m_trig, stop: m_stop, strt: m_start};
    cq.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit ab, input bit [1:0] pos,
                     input bit sh, input bit th);
    int sig;
    @(negedge src_clk);
    sig = int'($urandom_range(0, 15));
    start = st; abort = ab; trigger_pos = pos; store_hit = sh; trigger_hit = th;
    signals_in = 4'(sig);
    model_step(st, ab, pos, sh, th, sig);
    mon_on = 1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_wr_ena"}, int'(ram_wr_ena), 0);
    chk({tag, "_wr_addr"}, int'(ram_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(ram_wr_data), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_start_addr"}, int'(start_addr), 0);
    chk({tag, "_trigger_addr"}, int'(trigger_addr), 0);
    chk({tag, "_stop_addr"}, int'(stop_addr), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 0, 0);
  endtask

  // monitor: one expected record per clock edge, one write record per strobe
  initial begin
    cyc_t e;
    wr_t  w;
    forever begin
      @(posedge src_clk);
      #1;
      if (mon_on) begin
        if (cq.size() == 0) chk("cycle_queue_nonempty", 0, 1);
        else begin
          e = cq.pop_front();
          chk("state", int'(state), e.st);
          chk("ram_wr_ena", int'(ram_wr_ena), e.ena);
          chk("done", int'(done), e.dn);
          chk("trigger_addr", int'(trigger_addr), e.trig);
          chk("stop_addr", int'(stop_addr), e.stop);
          chk("start_addr", int'(start_addr), e.strt);
          if (ram_wr_ena && e.ena == 1) begin
            if (wq.size() == 0) chk("write_queue_nonempty", 0, 1);
            else begin
              w = wq.pop_front();
              chk("ram_wr_addr", int'(ram_wr_addr), w.addr);
              chk("ram_wr_data", int'(ram_wr_data), w.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #3;
    check_zero_outputs("reset");
    @(negedge src_clk);
    src_reset = 1'b0;

    // middle trigger; early trigger at sample 2 ignored, accepted at sample 6
    cyc(1, 0, 2'd1, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 2'd1, 1, (k == 2 || k == 6));
    idle(2);

    // trigger at start
    cyc(1, 0, 2'd0, 0, 0);
    for (int k = 0; k < 11; k++) cyc(0, 0, 2'd0, 1, 1);
    idle(2);

    // trigger at end: no post-trigger phase
    cyc(1, 0, 2'd2, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 2'd2, 1, 1);
    idle(2);

    // toggling store_hit, trigger on a non-store cycle once fill reached 4
    cyc(1, 0, 2'd3, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 2'd3, (k % 2 == 0), (k == 7));
    idle(2);

    // start ignored in PRE, then abort during POST
    cyc(1, 0, 2'd1, 0, 0);
    for (int k = 0; k < 7; k++) cyc((k == 2), 0, 2'd0, 1, (k == 5));
    cyc(0, 1, 2'd1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 2'd1, 1, 1);

    // asynchronous reset in the middle of PRE_TRIGGER
    cyc(1, 0, 2'd1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 2'd1, 1, 0);
    @(posedge src_clk);
    #3;
    mon_on = 0;
    src_reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    cq.delete(); wq.delete();
    phase = 0; nw = 0; m_trig = 0; m_stop = 0; m_start = 0;
    start = 0; abort = 0; store_hit = 0; trigger_hit = 0;
    repeat (2) @(negedge src_clk);
    src_reset = 1'b0;
    cyc(1, 0, 2'd0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 2'd0, 1, (k == 0));
    idle(2);

    // randomized traffic
    for (int k = 0; k < 600; k++)
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0));
    idle(2);

    @(posedge src_clk);
    #3;
    mon_on = 0;
    chk("writes_left_unmatched", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
